// File: rtl/priority_encoder_hs.sv
// Registered N-to-log2(N) priority encoder. It has a valid/ready handshake on both sides and a saturating error counter.
// Latency is 1 cycle from accept to out_valid. in_ready passes backpressure straight through: !out_valid || out_ready.
module priority_encoder_hs #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CW        = 8,
  localparam int IW       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IW-1:0]    out_idx,
  output logic             out_none,
  output logic             out_multi,
  input  logic             clr_err,
  output logic [CW-1:0]    err_count
);

  logic             r_vld;
  logic [IW-1:0]    r_idx;
  logic             r_none;
  logic             r_multi;
  logic [CW-1:0]    r_err;

  logic             w_accept;
  logic [IW-1:0]    w_idx;
  logic             w_none;
  logic             w_multi;
  logic             w_bad;
  logic             w_err_sat;

  // The reset term keeps in_ready high during reset, even while a stale result is still registered.
  assign in_ready  = rst || !r_vld || out_ready;
  assign w_accept  = in_valid && in_ready && !rst;

  assign w_none    = (in_data == '0);
  // A vector has more than one bit set exactly when clearing its lowest set bit leaves something behind.
  assign w_multi   = ((in_data & (in_data - WIDTH'(1))) != '0);
  assign w_bad     = w_none || w_multi;
  assign w_err_sat = (r_err == {CW{1'b1}});

  // The last write wins. The scan direction picks the highest or the lowest set bit.
  // With no bit set, w_idx stays at 0.
  always_comb begin
    w_idx = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (in_data[i]) w_idx = IW'(i);
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (in_data[i]) w_idx = IW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld   <= 1'b0;
      r_idx   <= '0;
      r_none  <= 1'b0;
      r_multi <= 1'b0;
    end else if (w_accept) begin
      r_vld   <= 1'b1;
      r_idx   <= w_idx;
      r_none  <= w_none;
      r_multi <= w_multi;
    end else if (out_ready) begin
      r_vld   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_err) begin
      r_err <= '0;
    end else if (w_accept && w_bad && !w_err_sat) begin
      r_err <= r_err + CW'(1);
    end
  end

  assign out_valid = r_vld;
  assign out_idx   = r_idx;
  assign out_none  = r_none;
  assign out_multi = r_multi;
  assign err_count = r_err;

endmodule
